// File: rtl/stream_mem_writer.sv
// Packs an 8-bit stream into little-endian 32-bit words and writes them to an on-chip memory.
// Optional running checksum of issued writes: define STREAM_MEM_WRITER_CSUM_EN.
module stream_mem_writer #(
  parameter int DEPTH  = 5120,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [14:0]       length_bytes,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_clken,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       csum
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [14:0]       rem_q;
  logic [1:0]        cnt_q;
  logic [31:0]       buf_q;
  logic [31:0]       wd_q;
  logic [3:0]        be_q;
  logic              in_ready_q, cs_q, write_q, busy_q, done_q, err_q;

  logic [31:0]       word_d;
  logic [3:0]        be_d;
  logic [ADDR_W-1:0] addr_inc;
  logic              last_byte, bad_base, issue, start_ok;

  always_comb begin
    word_d = buf_q;
    word_d[{cnt_q, 3'b000} +: 8] = in_data;
    case (cnt_q)
      2'd0:    be_d = 4'b0001;
      2'd1:    be_d = 4'b0011;
      2'd2:    be_d = 4'b0111;
      default: be_d = 4'b1111;
    endcase
    addr_inc  = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
    last_byte = (cnt_q == 2'd3) || (rem_q == 15'd1);
    bad_base  = 32'(base_addr) >= 32'(DEPTH);
    // A write presented while mem_clken is high is taken, even if abort arrives with it.
    issue     = (state_q == WRITE) && mem_clken;
    start_ok  = (state_q == IDLE) && start && !bad_base;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      wd_q       <= '0;
      be_q       <= '0;
      in_ready_q <= 1'b0;
      cs_q       <= 1'b0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort && state_q != IDLE) begin
        state_q    <= IDLE;
        rem_q      <= '0;
        cnt_q      <= '0;
        buf_q      <= '0;
        wd_q       <= '0;
        be_q       <= '0;
        in_ready_q <= 1'b0;
        cs_q       <= 1'b0;
        write_q    <= 1'b0;
        busy_q     <= 1'b0;
        if (issue) addr_q <= addr_inc;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              if (bad_base) begin
                err_q <= 1'b1;
              end else begin
                addr_q <= base_addr;
                rem_q  <= length_bytes;
                cnt_q  <= '0;
                buf_q  <= '0;
                busy_q <= 1'b1;
                if (length_bytes == 15'd0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q    <= FILL;
                  in_ready_q <= 1'b1;
                end
              end
            end
          end
          FILL: begin
            if (in_valid && in_ready_q) begin
              rem_q <= rem_q - 15'd1;
              if (last_byte) begin
                state_q    <= WRITE;
                in_ready_q <= 1'b0;
                cs_q       <= 1'b1;
                write_q    <= 1'b1;
                wd_q       <= word_d;
                be_q       <= be_d;
                buf_q      <= '0;
                cnt_q      <= '0;
              end else begin
                buf_q <= word_d;
                cnt_q <= cnt_q + 2'd1;
              end
            end
          end
          WRITE: begin
            if (mem_clken) begin
              cs_q    <= 1'b0;
              write_q <= 1'b0;
              wd_q    <= '0;
              be_q    <= '0;
              addr_q  <= addr_inc;
              if (rem_q == 15'd0) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q    <= FILL;
                in_ready_q <= 1'b1;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef STREAM_MEM_WRITER_CSUM_EN
  logic [31:0] csum_q;
  always_ff @(posedge clk) begin
    if (reset)         csum_q <= '0;
    else if (start_ok) csum_q <= '0;
    else if (issue)    csum_q <= csum_q + wd_q;
  end
  assign csum = csum_q;
`else
  logic unused_csum;
  assign unused_csum = start_ok;
  assign csum = 32'd0;
`endif

  assign in_ready   = in_ready_q;
  assign address    = addr_q;
  assign byteenable = be_q;
  assign chipselect = cs_q;
  assign write      = write_q;
  assign writedata  = wd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_stream_mem_writer.sv
// Scoreboard bench for stream_mem_writer: expected writes queued by stimulus, checked by a monitor.
module tb_stream_mem_writer;
  localparam int ADDR_W = 13;

  logic              clk = 1'b0;
  logic              reset, start, abort, in_valid, mem_clken;
  logic [ADDR_W-1:0] base_addr;
  logic [14:0]       length_bytes;
  logic [7:0]        in_data;
  logic              in_ready, chipselect, write, busy, done, err;
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic [31:0]       writedata, csum;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  done_cnt = 0;

  always #5 clk = ~clk;

  stream_mem_writer #(.DEPTH(5120), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .length_bytes(length_bytes),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_clken(mem_clken), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .write(write), .writedata(writedata),
    .busy(busy), .done(done), .err(err), .csum(csum)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every write taken by the memory must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && done) done_cnt++;
    if (!reset && write && mem_clken) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%04h data 0x%08h, expected none", address, writedata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(address), 32'(e.addr));
        check("wr_be", 32'(byteenable), 32'(e.be));
        check("wr_data", writedata, e.data);
        check("wr_cs", 32'(chipselect), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [14:0] l);
    start = 1'b1; base_addr = b; length_bytes = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int   k;
    in_valid = 1'b1; in_data = b; rdy = 1'b0; k = 0;
    while (!rdy && k < 100) begin
      @(negedge clk); rdy = in_ready;
      tick();
      k++;
    end
    in_valid = 1'b0;
    if (!rdy) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check(name, 32'(got), 32'd1);
    tick();
  endtask

  function automatic logic [31:0] csum_exp(input logic [31:0] v);
`ifdef STREAM_MEM_WRITER_CSUM_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_write"}, 32'(write), 32'd0);
    check({tag, "_cs"}, 32'(chipselect), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_addr"}, 32'(address), 32'd0);
    check({tag, "_wdata"}, writedata, 32'd0);
    check({tag, "_be"}, 32'(byteenable), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_csum"}, csum, 32'd0);
  endtask

  initial begin
    logic [ADDR_W-1:0] h_addr;
    logic [31:0]       h_data;
    logic [3:0]        h_be;

    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; mem_clken = 1'b1;
    base_addr = '0; length_bytes = '0; in_data = '0;
    tick(); tick();
    check_idle_zero("reset");
    reset = 1'b0;
    tick();

    // Two full words from address 0.
    exp_q.push_back('{addr: 13'd0, be: 4'b1111, data: 32'h04030201});
    exp_q.push_back('{addr: 13'd1, be: 4'b1111, data: 32'h08070605});
    do_start(13'd0, 15'd8);
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    wait_done("done_len8");
    check("csum_len8", csum, csum_exp(32'h0C0A0806));
    check("busy_after_len8", 32'(busy), 32'd0);

    // Wrap from the last word to 0 with a partial tail word.
    exp_q.push_back('{addr: 13'd5119, be: 4'b1111, data: 32'h14131211});
    exp_q.push_back('{addr: 13'd0, be: 4'b0011, data: 32'h00001615});
    do_start(13'd5119, 15'd6);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 + i));
    wait_done("done_wrap");
    check("csum_wrap", csum, csum_exp(32'h14132826));

    // Memory stall: outputs hold, a single write goes through.
    exp_q.push_back('{addr: 13'd100, be: 4'b1111, data: 32'hA4A3A2A1});
    do_start(13'd100, 15'd4);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    mem_clken = 1'b0;
    send_byte(8'hA4);
    h_addr = address; h_data = writedata; h_be = byteenable;
    check("stall_write", 32'(write), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", 32'(address), 32'(h_addr));
      check("stall_data", writedata, h_data);
      check("stall_be", 32'(h_be), 32'(byteenable));
      check("stall_write_held", 32'(write), 32'd1);
    end
    mem_clken = 1'b1;
    tick();
    check("stall_addr_adv", 32'(address), 32'd101);
    check("stall_write_drop", 32'(write), 32'd0);
    wait_done("done_stall");

    // Zero length completes straight away; out-of-range base is rejected.
    do_start(13'd50, 15'd0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_write", 32'(write), 32'd0);
    tick();
    check("len0_done_clr", 32'(done), 32'd0);
    do_start(13'd5120, 15'd4);
    check("badbase_err", 32'(err), 32'd1);
    check("badbase_busy", 32'(busy), 32'd0);
    tick();
    check("badbase_err_clr", 32'(err), 32'd0);
    check("badbase_busy2", 32'(busy), 32'd0);

    // Abort mid-word drops the bytes; the next transfer is normal.
    do_start(13'd200, 15'd8);
    send_byte(8'hEE); send_byte(8'hEF);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd0);
    check("abort_write", 32'(write), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    exp_q.push_back('{addr: 13'd10, be: 4'b0111, data: 32'h00232221});
    do_start(13'd10, 15'd3);
    send_byte(8'h21); send_byte(8'h22); send_byte(8'h23);
    wait_done("done_after_abort");
    check("csum_after_abort", csum, csum_exp(32'h00232221));

    // Reset during a stalled write.
    do_start(13'd300, 15'd4);
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
    mem_clken = 1'b0;
    send_byte(8'h34);
    check("pre_reset_write", 32'(write), 32'd1);
    reset = 1'b1;
    tick();
    check_idle_zero("midwrite_reset");
    reset = 1'b0; mem_clken = 1'b1;
    tick(); tick();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'd5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
